ifu_exu_inst_queue: RTL and testbench

- Parametrised multi-lane instruction queue between the instruction fetch unit (ifu_top) and the execute unit (exu_top).
- Generalises the fixed four-lane direct valid/allowIn hookup: configurable lane counts on each side and a configurable depth.
- Adds buffering so fetch and execute decouple, plus a flush.
- Strictly in-order: lane 0 is always the oldest instruction on either side.

---
 rtl/mercury_pkg.sv | 10 +
 rtl/mercury_prefix_cnt.sv | 20 ++
 rtl/ifu_exu_inst_queue.sv | 84 ++++++++
 tb/tb_ifu_exu_inst_queue.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mercury_pkg.sv
// Shared types and default geometry for the IFU-to-EXU instruction path.
package mercury_pkg;

  localparam int INST_W        = 32;
  localparam int DEF_IN_LANES  = 4;
  localparam int DEF_OUT_LANES = 4;

  typedef logic [INST_W-1:0] inst_t;

endpackage

// File: rtl/mercury_prefix_cnt.sv
// Counts the run of ones starting at bit 0 of an N-bit vector.
module mercury_prefix_cnt #(
  parameter int N = 4
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N):0]   cnt
);

  logic run;

  always_comb begin
    cnt = '0;
    run = 1'b1;
    for (int i = 0; i < N; i++) begin
      run = run & vec[i];
      if (run) cnt = cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ifu_exu_inst_queue.sv
// Multi-lane in-order instruction queue decoupling fetch from execute.
// Lane 0 is always the oldest entry on both the enqueue and dequeue side.
module ifu_exu_inst_queue
  import mercury_pkg::*;
#(
  parameter int IN_LANES  = DEF_IN_LANES,
  parameter int OUT_LANES = DEF_OUT_LANES,
  parameter int DEPTH     = 16,
  parameter int DATA_W    = INST_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [IN_LANES-1:0]           in_valid,
  output logic [IN_LANES-1:0]           in_allowIn,
  input  logic [IN_LANES*DATA_W-1:0]    in_data,
  output logic [OUT_LANES-1:0]          out_valid,
  input  logic [OUT_LANES-1:0]          out_allowIn,
  output logic [OUT_LANES*DATA_W-1:0]   out_data,
  output logic [$clog2(DEPTH):0]        occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(IN_LANES) + 1;
  localparam int OW = $clog2(OUT_LANES) + 1;

  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [CW:0]       space;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IN_LANES-1:0]  push_mask;
  logic [OUT_LANES-1:0] pop_mask;
  logic [IW-1:0]        push_n;
  logic [OW-1:0]        pop_n;

  // Credits come only from the registered count, never from same-cycle pops.
  assign space = (CW+1)'(DEPTH) - {1'b0, count};

  for (genvar k = 0; k < IN_LANES; k++) begin : g_in
    assign in_allowIn[k] = rst & (space > (CW+1)'(k));
  end

  for (genvar k = 0; k < OUT_LANES; k++) begin : g_out
    assign out_valid[k] = rst & (count > CW'(k));
    assign out_data[k*DATA_W +: DATA_W] = mem[rd_ptr + PW'(k)];
  end

  assign push_mask = in_valid & in_allowIn;
  assign pop_mask  = out_valid & out_allowIn;
  assign occupancy = count;

  mercury_prefix_cnt #(.N(IN_LANES)) u_push_cnt (
    .vec (push_mask),
    .cnt (push_n)
  );

  mercury_prefix_cnt #(.N(OUT_LANES)) u_pop_cnt (
    .vec (pop_mask),
    .cnt (pop_n)
  );

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_n);
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + CW'(push_n) - CW'(pop_n);
    end
  end

  // Storage has no reset; a write in a flush cycle lands but is orphaned.
  always_ff @(posedge clk) begin
    for (int k = 0; k < IN_LANES; k++) begin
      if (k < int'(push_n))
        mem[wr_ptr + PW'(k)] <= in_data[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_ifu_exu_inst_queue.sv
// Bench for ifu_exu_inst_queue: vector table plus queue-based scoreboard.
module tb_ifu_exu_inst_queue;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   in_valid;
  logic [3:0]   in_allowIn;
  logic [127:0] in_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_allowIn;
  logic [127:0] out_data;
  logic [4:0]   occupancy;

  int compared = 0;
  int mismatched = 0;
  int seq = 0;
  logic [31:0] sbq [$];

  typedef struct {
    logic [3:0] iv;
    logic [3:0] oa;
    logic       fl;
    logic [3:0] ea;
    logic [3:0] ev;
    int         eo;
  } vec_t;

  vec_t tbl [22];

  ifu_exu_inst_queue #(
    .IN_LANES(4), .OUT_LANES(4), .DEPTH(16), .DATA_W(32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_allowIn  (in_allowIn),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_allowIn (out_allowIn),
    .out_data    (out_data),
    .occupancy   (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int idx, input vec_t v);
    logic [31:0] w [4];
    int pn, qn, mcnt;
    logic run;
    in_valid    = v.iv;
    out_allowIn = v.oa;
    flush       = v.fl;
    for (int k = 0; k < 4; k++) begin
      w[k] = 32'hD000_0000 | 32'(seq);
      seq++;
      in_data[k*32 +: 32] = w[k];
    end
    #1;
    check($sformatf("row%0d allow", idx), 32'(in_allowIn), 32'(v.ea));
    check($sformatf("row%0d valid", idx), 32'(out_valid), 32'(v.ev));
    check($sformatf("row%0d occ", idx), 32'(occupancy), 32'(v.eo));
    mcnt = sbq.size();
    for (int k = 0; k < 4; k++)
      if (k < mcnt)
        check($sformatf("row%0d data%0d", idx, k), out_data[k*32 +: 32], sbq[k]);
    pn = 0; run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run = run & v.iv[k] & ((16 - mcnt) > k);
      if (run) pn++;
    end
    qn = 0; run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run = run & v.oa[k] & (mcnt > k);
      if (run) qn++;
    end
    if (v.fl) sbq.delete();
    else begin
      for (int k = 0; k < qn; k++) void'(sbq.pop_front());
      for (int k = 0; k < pn; k++) sbq.push_back(w[k]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //          iv       oa       fl    ea       ev       occ
    tbl[0]  = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000, 0};
    tbl[1]  = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b1111, 4};
    tbl[2]  = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b1111, 8};
    tbl[3]  = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b1111, 12};
    tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b1111, 16};
    tbl[5]  = '{4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b1111, 16};
    tbl[6]  = '{4'b1111, 4'b0000, 1'b0, 4'b0011, 4'b1111, 14};
    tbl[7]  = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 4'b1111, 16};
    tbl[8]  = '{4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b1111, 12};
    tbl[9]  = '{4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b1111, 8};
    tbl[10] = '{4'b1011, 4'b1101, 1'b0, 4'b1111, 4'b1111, 4};
    tbl[11] = '{4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b1111, 5};
    tbl[12] = '{4'b0000, 4'b0001, 1'b0, 4'b1111, 4'b0001, 1};
    tbl[13] = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000, 0};
    tbl[14] = '{4'b1111, 4'b1111, 1'b0, 4'b1111, 4'b1111, 4};
    tbl[15] = '{4'b1111, 4'b1111, 1'b0, 4'b1111, 4'b1111, 4};
    tbl[16] = '{4'b0000, 4'b0011, 1'b0, 4'b1111, 4'b1111, 4};
    tbl[17] = '{4'b1111, 4'b0011, 1'b0, 4'b1111, 4'b0011, 2};
    tbl[18] = '{4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b1111, 4};
    tbl[19] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 4'b1111, 4};
    tbl[20] = '{4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b0000, 0};
    tbl[21] = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000, 0};

    rst = 1'b0; flush = 1'b0; in_valid = 4'b1111; out_allowIn = 4'b0000; in_data = '0;
    repeat (2) begin
      @(negedge clk);
      #1;
      check("reset allow", 32'(in_allowIn), 32'h0);
      check("reset valid", 32'(out_valid), 32'h0);
    end
    rst = 1'b1; in_valid = 4'b0000;
    @(negedge clk);

    for (int i = 0; i < 22; i++) step(i, tbl[i]);

    // Reset asserted together with flush: reset wins and blanks the handshake.
    rst = 1'b0; flush = 1'b1; in_valid = 4'b1111; out_allowIn = 4'b1111;
    #1;
    check("rstflush allow", 32'(in_allowIn), 32'h0);
    check("rstflush valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; flush = 1'b0; in_valid = 4'b0000; out_allowIn = 4'b0000;
    sbq.delete();
    #1;
    check("post-rst occ", 32'(occupancy), 32'h0);
    check("post-rst valid", 32'(out_valid), 32'h0);
    check("post-rst allow", 32'(in_allowIn), 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
